// File: rtl/voxel_feature_streamer.sv
// voxel_feature_streamer: per-frame reader of the voxel bin-count memory.
// Streams saturated, tail-masked feature beats to the classifier, then awaits its result.
module voxel_feature_streamer #(
  parameter int NUM_CELLS       = 1024,
  parameter int PARALLEL_INPUTS = 4,
  parameter int COUNT_BITS      = 8,
  parameter int VALUE_BITS      = 6,
  parameter bit CLEAR_ON_READ   = 1'b1,
  parameter int TIMEOUT_CYCLES  = 64,
  localparam int BEATS      = (NUM_CELLS + PARALLEL_INPUTS - 1) / PARALLEL_INPUTS,
  localparam int WADDR_BITS = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  trigger,
  output logic                                  busy,
  output logic                                  bin_rd_en,
  output logic [WADDR_BITS-1:0]                 bin_rd_addr,
  input  logic [PARALLEL_INPUTS*COUNT_BITS-1:0] bin_rd_data,
  output logic                                  bin_clr_en,
  output logic [WADDR_BITS-1:0]                 bin_clr_addr,
  output logic                                  cls_start,
  output logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feature_out,
  output logic                                  feature_valid,
  input  logic                                  result_valid,
  output logic                                  frame_done,
  output logic                                  timeout,
  output logic                                  overrun
);

  localparam int CNT_BITS = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int VMAX     = (1 << VALUE_BITS) - 1;
  localparam logic [WADDR_BITS-1:0] LAST_BEAT = WADDR_BITS'(BEATS - 1);
  localparam logic [CNT_BITS-1:0]   WAIT_LAST = CNT_BITS'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_BITS-1:0]   DRAIN_LAST = CNT_BITS'(1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_READ, S_DRAIN, S_WAIT} state_e;

  state_e                                state_q, state_d;
  logic [WADDR_BITS-1:0]                 beat_q, beat_d;
  logic [CNT_BITS-1:0]                   cnt_q, cnt_d;
  logic                                  frame_done_d, timeout_d;
  logic                                  rd_en_q, pipe_vld_q, clr_en_q;
  logic [WADDR_BITS-1:0]                 rd_addr_d1_q;
  logic                                  busy_q, cls_start_q, feature_valid_q;
  logic                                  frame_done_q, timeout_q, overrun_q;
  logic [PARALLEL_INPUTS*VALUE_BITS-1:0] feature_q, feature_d;

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    timeout_d    = 1'b0;
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_START;
      S_START: begin
        state_d = S_READ;
        beat_d  = '0;
      end
      S_READ: begin
        if (beat_q == LAST_BEAT) begin
          state_d = S_DRAIN;
          beat_d  = '0;
          cnt_d   = '0;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      // Two cycles let the last read flow through the data and feature registers.
      S_DRAIN: begin
        if (cnt_q == DRAIN_LAST) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (result_valid) begin
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
          cnt_d        = '0;
        end else if (cnt_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Lanes past the last real cell carry whatever the memory holds, so they are masked.
  always_comb begin
    feature_d = feature_q;
    if (pipe_vld_q) begin
      for (int p = 0; p < PARALLEL_INPUTS; p++) begin
        if (int'(rd_addr_d1_q) * PARALLEL_INPUTS + p >= NUM_CELLS)
          feature_d[p*VALUE_BITS +: VALUE_BITS] = '0;
        else if (int'(bin_rd_data[p*COUNT_BITS +: COUNT_BITS]) > VMAX)
          feature_d[p*VALUE_BITS +: VALUE_BITS] = VALUE_BITS'(VMAX);
        else
          feature_d[p*VALUE_BITS +: VALUE_BITS] = VALUE_BITS'(bin_rd_data[p*COUNT_BITS +: COUNT_BITS]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      beat_q          <= '0;
      cnt_q           <= '0;
      rd_en_q         <= 1'b0;
      pipe_vld_q      <= 1'b0;
      clr_en_q        <= 1'b0;
      rd_addr_d1_q    <= '0;
      busy_q          <= 1'b0;
      cls_start_q     <= 1'b0;
      feature_valid_q <= 1'b0;
      feature_q       <= '0;
      frame_done_q    <= 1'b0;
      timeout_q       <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      beat_q          <= beat_d;
      cnt_q           <= cnt_d;
      rd_en_q         <= (state_d == S_READ);
      pipe_vld_q      <= rd_en_q;
      clr_en_q        <= CLEAR_ON_READ && rd_en_q;
      rd_addr_d1_q    <= beat_q;
      busy_q          <= (state_d != S_IDLE);
      cls_start_q     <= (state_d == S_START);
      feature_valid_q <= pipe_vld_q;
      feature_q       <= feature_d;
      frame_done_q    <= frame_done_d;
      timeout_q       <= timeout_d;
      overrun_q       <= (state_q != S_IDLE) && trigger;
    end
  end

  assign busy          = busy_q;
  assign bin_rd_en     = rd_en_q;
  assign bin_rd_addr   = beat_q;
  assign bin_clr_en    = clr_en_q;
  assign bin_clr_addr  = rd_addr_d1_q;
  assign cls_start     = cls_start_q;
  assign feature_out   = feature_q;
  assign feature_valid = feature_valid_q;
  assign frame_done    = frame_done_q;
  assign timeout       = timeout_q;
  assign overrun       = overrun_q;

endmodule

// File: tb/tb_voxel_feature_streamer.sv
// tb_voxel_feature_streamer: directed, table-driven bench for voxel_feature_streamer
// with a 10-cell / 4-lane frame (3 beats, last beat partly tail-masked).
module tb_voxel_feature_streamer;

  localparam int NC    = 10;
  localparam int P     = 4;
  localparam int CB    = 8;
  localparam int VB    = 6;
  localparam int TO    = 16;
  localparam int BEATS = 3;
  localparam int AW    = 2;
  localparam int DW    = P * CB;
  localparam int FW    = P * VB;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  localparam logic [FW-1:0] F0 = {6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [FW-1:0] F1 = {6'd63, 6'd63, 6'd63, 6'd0};
  localparam logic [FW-1:0] F2 = {6'd0, 6'd0, 6'd5, 6'd5};

  logic          clk = 1'b0;
  logic          rst_n, trigger, result_valid;
  logic          busy, bin_rd_en, bin_clr_en, cls_start, feature_valid;
  logic          frame_done, timeout, overrun;
  logic [AW-1:0] bin_rd_addr, bin_clr_addr;
  logic [DW-1:0] bin_rd_data;
  logic [FW-1:0] feature_out;

  logic [DW-1:0] mem     [BEATS];
  logic [DW-1:0] memInit [BEATS];
  logic          memLoad;

  int testCount = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  voxel_feature_streamer #(
    .NUM_CELLS(NC), .PARALLEL_INPUTS(P), .COUNT_BITS(CB), .VALUE_BITS(VB),
    .CLEAR_ON_READ(1'b1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .trigger(trigger), .busy(busy),
    .bin_rd_en(bin_rd_en), .bin_rd_addr(bin_rd_addr), .bin_rd_data(bin_rd_data),
    .bin_clr_en(bin_clr_en), .bin_clr_addr(bin_clr_addr), .cls_start(cls_start),
    .feature_out(feature_out), .feature_valid(feature_valid), .result_valid(result_valid),
    .frame_done(frame_done), .timeout(timeout), .overrun(overrun)
  );

  // Bin memory: one-cycle read latency, read-before-write on a same-word clear.
  always @(posedge clk) begin
    if (bin_rd_en) bin_rd_data <= mem[bin_rd_addr];
    if (memLoad) begin
      for (int i = 0; i < BEATS; i++) mem[i] <= memInit[i];
    end else if (bin_clr_en) begin
      mem[bin_clr_addr] <= '0;
    end
  end

  typedef struct {
    logic          trig, res;
    logic          busy, cls, rdEn;
    logic [AW-1:0] rdAddr;
    logic          clrEn;
    logic [AW-1:0] clrAddr;
    logic          fv;
    logic [FW-1:0] feat;
    logic          done, tmo, ovr;
  } vec_t;

  vec_t vecs [9];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic trig, input logic res);
    @(negedge clk);
    trigger      = trig;
    result_valid = res;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input string tag);
    checkVal({tag, " busy"}, 32'(busy), 32'(v.busy));
    checkVal({tag, " cls_start"}, 32'(cls_start), 32'(v.cls));
    checkVal({tag, " rd_en"}, 32'(bin_rd_en), 32'(v.rdEn));
    if (v.rdEn) checkVal({tag, " rd_addr"}, 32'(bin_rd_addr), 32'(v.rdAddr));
    checkVal({tag, " clr_en"}, 32'(bin_clr_en), 32'(v.clrEn));
    if (v.clrEn) checkVal({tag, " clr_addr"}, 32'(bin_clr_addr), 32'(v.clrAddr));
    checkVal({tag, " feature_valid"}, 32'(feature_valid), 32'(v.fv));
    checkVal({tag, " feature_out"}, 32'(feature_out), 32'(v.feat));
    checkVal({tag, " frame_done"}, 32'(frame_done), 32'(v.done));
    checkVal({tag, " timeout"}, 32'(timeout), 32'(v.tmo));
    checkVal({tag, " overrun"}, 32'(overrun), 32'(v.ovr));
  endtask

  task automatic checkAllZero(input string tag);
    vec_t z;
    z = '{L, L, L, L, L, 2'd0, L, 2'd0, L, '0, L, L, L};
    checkOutput(z, tag);
  endtask

  task automatic loadMem();
    @(negedge clk);
    memLoad = 1'b1;
    @(negedge clk);
    memLoad = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tmoCycle, firstRd, firstRdAddr, firstFv, fvCount, doneCycle;
    logic doneSeen;
    logic [FW-1:0] beats [BEATS];

    rst_n        = 1'b0;
    trigger      = 1'b0;
    result_valid = 1'b0;
    memLoad      = 1'b1;
    memInit[0] = {8'd4, 8'd3, 8'd2, 8'd1};
    memInit[1] = {8'd200, 8'd70, 8'd63, 8'd0};
    memInit[2] = 32'h05050505;
    repeat (3) @(posedge clk);
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    memLoad = 1'b0;
    applyStimulus(L, L);

    // Row k: inputs present in frame cycle k, outputs expected in cycle k+1.
    vecs[0] = '{H, L, H, H, L, 2'd0, L, 2'd0, L, '0, L, L, L};
    vecs[1] = '{L, L, H, L, H, 2'd0, L, 2'd0, L, '0, L, L, L};
    vecs[2] = '{H, L, H, L, H, 2'd1, H, 2'd0, L, '0, L, L, H};
    vecs[3] = '{L, L, H, L, H, 2'd2, H, 2'd1, H, F0, L, L, L};
    vecs[4] = '{L, L, H, L, L, 2'd0, H, 2'd2, H, F1, L, L, L};
    vecs[5] = '{L, L, H, L, L, 2'd0, L, 2'd0, H, F2, L, L, L};
    vecs[6] = '{L, H, H, L, L, 2'd0, L, 2'd0, L, F2, L, L, L};
    vecs[7] = '{L, H, L, L, L, 2'd0, L, 2'd0, L, F2, H, L, L};
    vecs[8] = '{L, H, L, L, L, 2'd0, L, 2'd0, L, F2, L, L, L};
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].trig, vecs[i].res);
      checkOutput(vecs[i], $sformatf("row%0d", i));
    end

    for (int i = 0; i < BEATS; i++)
      checkVal($sformatf("cleared word%0d", i), 32'(mem[i]), 32'd0);

    // No result: timeout expected TO cycles after S_WAIT entry (frame cycle 7).
    applyStimulus(H, L);
    tmoCycle = 0;
    doneSeen = 1'b0;
    for (int n = 2; n < 60; n++) begin
      applyStimulus(L, L);
      if (frame_done) doneSeen = 1'b1;
      if (timeout) begin
        tmoCycle = n;
        break;
      end
    end
    checkVal("timeout cycle", 32'(tmoCycle), 32'(7 + TO));
    checkVal("timeout no frame_done", 32'(doneSeen), 32'd0);
    applyStimulus(L, L);
    checkVal("timeout pulse width", 32'(timeout), 32'd0);
    checkVal("busy after timeout", 32'(busy), 32'd0);

    // Trigger in the cycle S_WAIT exits is an overrun, not a new frame.
    applyStimulus(H, L);
    for (int k = 2; k < 8; k++) applyStimulus(L, L);
    applyStimulus(H, H);
    checkVal("exit frame_done", 32'(frame_done), 32'd1);
    checkVal("exit overrun", 32'(overrun), 32'd1);
    checkVal("exit cls_start", 32'(cls_start), 32'd0);
    applyStimulus(L, L);
    checkVal("exit no restart busy", 32'(busy), 32'd0);
    applyStimulus(L, L);
    checkVal("exit no restart rd_en", 32'(bin_rd_en), 32'd0);
    checkVal("exit no restart cls", 32'(cls_start), 32'd0);

    // Reset in the middle of S_READ, then a full fresh frame.
    loadMem();
    applyStimulus(H, L);
    applyStimulus(L, L);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkAllZero("mid-read reset");
    @(negedge clk);
    rst_n = 1'b1;
    loadMem();
    applyStimulus(H, L);
    checkVal("retrigger cls_start", 32'(cls_start), 32'd1);
    firstRd = 0; firstRdAddr = -1; firstFv = 0; fvCount = 0; doneCycle = 0;
    for (int k = 2; k < 12; k++) begin
      applyStimulus(L, (k == 8) ? H : L);
      if (bin_rd_en && firstRd == 0) begin
        firstRd     = k;
        firstRdAddr = int'(bin_rd_addr);
      end
      if (feature_valid) begin
        if (firstFv == 0) firstFv = k;
        if (fvCount < BEATS) beats[fvCount] = feature_out;
        fvCount++;
      end
      if (frame_done && doneCycle == 0) doneCycle = k;
    end
    checkVal("retrigger first rd cycle", 32'(firstRd), 32'd2);
    checkVal("retrigger first rd addr", 32'(firstRdAddr), 32'd0);
    checkVal("retrigger first fv cycle", 32'(firstFv), 32'd4);
    checkVal("retrigger beat count", 32'(fvCount), 32'(BEATS));
    checkVal("retrigger beat0", 32'(beats[0]), 32'(F0));
    checkVal("retrigger beat1", 32'(beats[1]), 32'(F1));
    checkVal("retrigger beat2", 32'(beats[2]), 32'(F2));
    checkVal("retrigger done cycle", 32'(doneCycle), 32'd8);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
